// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and sizes for the matrix-multiply stream feeder.
//                Holds the feeder state encoding, the datapath widths and a
//                helper that sizes a matrix from its two dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int DIM_W  = 4;   // matrix dimension width (0..15)
    localparam int ADDR_W = 14;  // element memory address width
    localparam int DATA_W = 8;   // element width
    localparam int CNT_W  = 10;  // element count width (max 2*15*15 = 450)

    // Buffer entry layout: {data, col_end, row_end}
    localparam int TAG_W  = DATA_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_STREAM   = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Element count of a rows x cols matrix.
    function automatic logic [CNT_W-1:0] dim_product(
        input logic [DIM_W-1:0] rows,
        input logic [DIM_W-1:0] cols
    );
        return CNT_W'(rows) * CNT_W'(cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_feed_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mm_feed_fifo
//  Description : Two-entry buffer holding prefetched elements together with
//                their end-of-row / end-of-matrix tags. The head entry is
//                presented combinationally on rdata.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                push, wdata        - write an entry (caller guarantees room)
//                pop                - drop the head entry (caller guarantees
//                                     the buffer is not empty)
//                rdata              - head entry
//                full, empty        - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_feed_fifo
    import mm_pkg::*;
#(
    parameter int WIDTH = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/mm_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mm_stream_feeder
//  Description : Reads two row-major matrices stored back to back in a
//                synchronous element memory and streams their elements to a
//                matrix-multiply engine, tagging the last element of every
//                row (col_end) and of every matrix (row_end).
//                Optional build macro MM_FEED_STALL_CNT_EN adds a saturating
//                16-bit stall counter output (stall_cnt).
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                start                    - begin a job (honoured in IDLE only)
//                m1_rows/m1_cols/m2_rows/m2_cols - matrix shapes (1..15)
//                base_addr                - address of matrix 1 element 0
//                mem_addr / mem_rdata     - memory read port, 1-cycle latency
//                busy                     - consumer back-pressure
//                in_data/col_end/row_end/in_valid - element stream
//                done                     - one-cycle end-of-job pulse
//                next_addr                - base_addr + element count
//                shape_err                - one-cycle pulse on rejected start
//                stall_cnt                - (optional) back-pressured cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_stream_feeder
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m1_rows,
    input  logic [DIM_W-1:0]  m1_cols,
    input  logic [DIM_W-1:0]  m2_rows,
    input  logic [DIM_W-1:0]  m2_cols,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              busy,
    output logic [DATA_W-1:0] in_data,
    output logic              col_end,
    output logic              row_end,
    output logic              in_valid,
    output logic              done,
    output logic [ADDR_W-1:0] next_addr,
    output logic              shape_err
`ifdef MM_FEED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;

    logic [DIM_W-1:0]  r_m1_cols;
    logic [DIM_W-1:0]  r_m2_cols;
    logic [DIM_W-1:0]  r_col_idx;     // column of the next element to issue
    logic [CNT_W-1:0]  r_n1;          // element count of matrix 1
    logic [CNT_W-1:0]  r_n;           // total element count of the job
    logic [CNT_W-1:0]  r_issued;      // addresses sent to memory so far
    logic [CNT_W-1:0]  r_consumed;    // elements accepted by the consumer
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_inflight;    // read data arrives this cycle
    logic              r_tag_col_end; // tags of the in-flight element
    logic              r_tag_row_end;
    logic              r_shape_err;

    logic              w_idle;
    logic              w_dims_ok;
    logic              w_accept;
    logic              w_active;
    logic              w_pop;
    logic              w_issue;
    logic              w_room;
    logic [1:0]        w_fill;
    logic              w_in_m2;
    logic [DIM_W-1:0]  w_cols;
    logic              w_col_end;
    logic              w_row_end;
    logic [CNT_W-1:0]  w_total;

    logic [TAG_W-1:0]  w_fifo_wdata;
    logic [TAG_W-1:0]  w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_idle    = (r_state == ST_IDLE);
    assign w_dims_ok = (|m1_rows) && (|m1_cols) && (|m2_rows) && (|m2_cols);
    assign w_accept  = w_idle && start && w_dims_ok;
    assign w_active  = (r_state == ST_PREFETCH) || (r_state == ST_STREAM);
    assign w_total   = dim_product(m1_rows, m1_cols) + dim_product(m2_rows, m2_cols);

    assign in_valid  = ~w_fifo_empty;
    assign w_pop     = in_valid && !busy;

    // Occupancy of the buffer as 0/1/2.
    assign w_fill    = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);

    // A read issued now lands in the buffer at the next edge, so it needs a
    // slot that is still free after this edge's pop and the in-flight push.
    // Counting the pop keeps the stream gap-free with only two entries.
    assign w_room    = ({1'b0, w_fill} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_issue   = w_active && (r_issued != r_n) && w_room;

    // Tags for the element addressed by r_mem_addr. The last element of
    // matrix 1 always closes a row, so r_col_idx is already 0 when matrix 2
    // begins.
    assign w_in_m2   = (r_issued >= r_n1);
    assign w_cols    = w_in_m2 ? r_m2_cols : r_m1_cols;
    assign w_col_end = (r_col_idx == (w_cols - DIM_W'(1)));
    assign w_row_end = (r_issued == (r_n1 - CNT_W'(1))) ||
                       (r_issued == (r_n - CNT_W'(1)));

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                // First element enters the buffer at this edge.
                if (r_inflight) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_pop && (r_consumed == (r_n - CNT_W'(1)))) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Job registers and read-address generation
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m1_cols     <= '0;
            r_m2_cols     <= '0;
            r_col_idx     <= '0;
            r_n1          <= '0;
            r_n           <= '0;
            r_issued      <= '0;
            r_consumed    <= '0;
            r_mem_addr    <= '0;
            r_next_addr   <= '0;
            r_inflight    <= 1'b0;
            r_tag_col_end <= 1'b0;
            r_tag_row_end <= 1'b0;
            r_shape_err   <= 1'b0;
        end else begin
            r_shape_err <= w_idle && start && !w_dims_ok;

            if (w_accept) begin
                r_m1_cols   <= m1_cols;
                r_m2_cols   <= m2_cols;
                r_n1        <= dim_product(m1_rows, m1_cols);
                r_n         <= w_total;
                r_mem_addr  <= base_addr;
                r_next_addr <= base_addr + ADDR_W'(w_total);
                r_col_idx   <= '0;
                r_issued    <= '0;
                r_consumed  <= '0;
                r_inflight  <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    // Address arithmetic wraps naturally at 2^ADDR_W.
                    r_mem_addr    <= r_mem_addr + ADDR_W'(1);
                    r_issued      <= r_issued + CNT_W'(1);
                    r_col_idx     <= w_col_end ? '0 : (r_col_idx + DIM_W'(1));
                    r_tag_col_end <= w_col_end;
                    r_tag_row_end <= w_row_end;
                end
                if (w_pop) begin
                    r_consumed <= r_consumed + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------------
    assign w_fifo_wdata = {mem_rdata, r_tag_col_end, r_tag_row_end};

    mm_feed_fifo #(
        .WIDTH (TAG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .wdata (w_fifo_wdata),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------------
    // Outputs (stream outputs forced to zero whenever nothing is presented)
    // ------------------------------------------------------------------------
    assign in_data   = in_valid ? w_fifo_rdata[TAG_W-1:2] : '0;
    assign col_end   = in_valid && w_fifo_rdata[1];
    assign row_end   = in_valid && w_fifo_rdata[0];
    assign done      = (r_state == ST_DONE);
    assign mem_addr  = r_mem_addr;
    assign next_addr = r_next_addr;
    assign shape_err = r_shape_err;

`ifdef MM_FEED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (in_valid && busy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mm_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_stream_feeder
//  Description : Directed self-checking bench for mm_stream_feeder. A
//                synchronous memory model returns an address-derived byte so
//                every streamed element can be traced to its address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_stream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  m1_rows, m1_cols, m2_rows, m2_cols;
    logic [13:0] base_addr;
    logic [13:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [7:0]  in_data;
    logic        col_end, row_end, in_valid, done, shape_err;
    logic [13:0] next_addr;
`ifdef MM_FEED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mm_stream_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m1_rows   (m1_rows),
        .m1_cols   (m1_cols),
        .m2_rows   (m2_rows),
        .m2_cols   (m2_cols),
        .base_addr (base_addr),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .in_data   (in_data),
        .col_end   (col_end),
        .row_end   (row_end),
        .in_valid  (in_valid),
        .done      (done),
        .next_addr (next_addr),
        .shape_err (shape_err)
`ifdef MM_FEED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Memory contents: low address byte XOR high address bits.
    function automatic logic [7:0] mem_val(input int a);
        logic [13:0] av;
        av = a[13:0];
        return av[7:0] ^ {2'b00, av[13:8]};
    endfunction

    always @(posedge clk) mem_rdata <= mem_val(int'(mem_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Starts a job, scrambles the inputs after acceptance, checks every
    // element, optionally stalls element hold_k for hold_n cycles (poking
    // start meanwhile), then checks FLUSH, DONE and next_addr.
    task automatic run_job(input int base, input int r1, input int c1,
                           input int r2, input int c2,
                           input int hold_k, input int hold_n);
        int n1, n, j;
        logic [10:0] exp_v;
        logic [10:0] held;
        logic ce, re;
        n1 = r1 * c1;
        n  = n1 + r2 * c2;
        @(negedge clk);
        m1_rows = 4'(r1); m1_cols = 4'(c1); m2_rows = 4'(r2); m2_cols = 4'(c2);
        base_addr = 14'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m1_rows = 4'd0; m1_cols = 4'd0; m2_rows = 4'd7; m2_cols = 4'd9;
        base_addr = 14'h2AAA;
        check("lat_e0", {31'd0, in_valid}, 32'd0);
        @(negedge clk);
        check("lat_e1", {31'd0, in_valid}, 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < n1) begin
                ce = ((k % c1) == c1 - 1);
                re = (k == n1 - 1);
            end else begin
                j  = k - n1;
                ce = ((j % c2) == c2 - 1);
                re = (j == r2 * c2 - 1);
            end
            exp_v = {1'b1, mem_val(base + k), ce, re};
            check($sformatf("elem%0d", k), {21'd0, in_valid, in_data, col_end, row_end},
                  {21'd0, exp_v});
            if (k == hold_k) begin
                held = exp_v;
                busy = 1'b1;
                start = 1'b1;
                m1_rows = 4'd1; m1_cols = 4'd1; m2_rows = 4'd1; m2_cols = 4'd1;
                base_addr = 14'd999;
                for (int h = 1; h <= hold_n; h++) begin
                    @(negedge clk);
                    check($sformatf("hold%0d", h), {21'd0, in_valid, in_data, col_end, row_end},
                          {21'd0, held});
                    if (h == hold_n) begin
                        busy  = 1'b0;
                        start = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        check("flush", {28'd0, in_valid, col_end, row_end, done}, 32'd0);
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("done_valid", {31'd0, in_valid}, 32'd0);
        check("next_addr", {18'd0, next_addr}, 32'((base + n) % 16384));
`ifdef MM_FEED_STALL_CNT_EN
        check("stall_cnt", {16'd0, stall_cnt}, (hold_k >= 0) ? 32'(hold_n) : 32'd0);
`endif
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; busy = 1'b0;
        m1_rows = 4'd0; m1_cols = 4'd0; m2_rows = 4'd0; m2_cols = 4'd0;
        base_addr = 14'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_stream", {21'd0, in_valid, in_data, col_end, row_end}, 32'd0);
        check("rst_flags", {30'd0, done, shape_err}, 32'd0);
        check("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
        check("rst_next_addr", {18'd0, next_addr}, 32'd0);
`ifdef MM_FEED_STALL_CNT_EN
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // 2x3 * 3x2 from address 0, no back-pressure
        run_job(0, 2, 3, 3, 2, -1, 0);
        // Same job, element 4 held for three busy cycles, start poked meanwhile
        run_job(0, 2, 3, 3, 2, 4, 3);
        // 1x1 * 1x1 across the address wrap
        run_job(16383, 1, 1, 1, 1, -1, 0);

        // Zero dimension rejected
        @(negedge clk);
        m1_rows = 4'd2; m1_cols = 4'd3; m2_rows = 4'd3; m2_cols = 4'd0;
        base_addr = 14'd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("shape_err_hi", {30'd0, shape_err, in_valid}, 32'd2);
        @(negedge clk);
        check("shape_err_lo", {30'd0, shape_err, in_valid}, 32'd0);
        repeat (2) @(negedge clk);
        check("rej_idle", {30'd0, in_valid, done}, 32'd0);
        check("rej_next_addr", {18'd0, next_addr}, 32'd1);

        // Reset in the middle of a 15x15 * 15x15 job
        @(negedge clk);
        m1_rows = 4'd15; m1_cols = 4'd15; m2_rows = 4'd15; m2_cols = 4'd15;
        base_addr = 14'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        repeat (6) @(negedge clk);
        check("abort_elem5", {23'd0, in_valid, in_data}, {23'd0, 1'b1, mem_val(105)});
        rst = 1'b1;
        @(negedge clk);
        check("abort_stream", {21'd0, in_valid, in_data, col_end, row_end}, 32'd0);
        check("abort_flags", {30'd0, done, shape_err}, 32'd0);
        check("abort_mem_addr", {18'd0, mem_addr}, 32'd0);
        check("abort_next_addr", {18'd0, next_addr}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", {30'd0, done, in_valid}, 32'd0);

        // Full-size job from a new base after the abort
        run_job(5000, 15, 15, 15, 15, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
